// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and helpers for the seven-segment scan
//                driver. Glyphs are active-low, bit 6 = segment a ... bit 0 =
//                segment g.
//  Contents    : SEG_BLANK, SEG_0..SEG_F glyph constants,
//                seg7_glyph(nibble) hex-to-glyph lookup function.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;

   function automatic logic [6:0] seg7_glyph(input logic [3:0] i_nibble);
      logic [6:0] v_seg;
      case (i_nibble)
         4'h0:    v_seg = SEG_0;
         4'h1:    v_seg = SEG_1;
         4'h2:    v_seg = SEG_2;
         4'h3:    v_seg = SEG_3;
         4'h4:    v_seg = SEG_4;
         4'h5:    v_seg = SEG_5;
         4'h6:    v_seg = SEG_6;
         4'h7:    v_seg = SEG_7;
         4'h8:    v_seg = SEG_8;
         4'h9:    v_seg = SEG_9;
         4'hA:    v_seg = SEG_A;
         4'hB:    v_seg = SEG_B;
         4'hC:    v_seg = SEG_C;
         4'hD:    v_seg = SEG_D;
         4'hE:    v_seg = SEG_E;
         default: v_seg = SEG_F;
      endcase
      return v_seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph_rom
//  Description : Combinational 4-bit hex nibble to active-low 7-segment glyph.
//  Ports       : i_nibble [3:0] - hex digit in
//                o_seg    [6:0] - glyph out, active-low, [6]=a ... [0]=g
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = seg7_glyph(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for DIGITS common-anode seven-segment
//                digits. Tear-free value update through a load/ready
//                handshake (applied on frame boundaries), leading-zero
//                blanking, per-digit decimal point and per-digit blink.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_value           - nibble i shown on digit i
//                i_load / o_ready  - capture strobe / no update pending
//                i_blank_lz        - leading-zero blanking enable (live)
//                i_dp_in           - per-digit decimal point request (live)
//                i_blink_en        - per-digit blink enable (live)
//                o_seg, o_dp       - segments a..g and dp, active-low
//                o_an              - anode enables, active-low one-hot
//                o_frame_tick      - one-cycle pulse after each frame end
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic                  i_load,
   output logic                  o_ready,
   input  logic                  i_blank_lz,
   input  logic [DIGITS-1:0]     i_dp_in,
   input  logic [DIGITS-1:0]     i_blink_en,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_an,
   output logic                  o_frame_tick
);

   localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PCNT_W-1:0] c_LAST_PCNT = PCNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(DIGITS - 1);
   localparam logic [FCNT_W-1:0] c_LAST_FCNT = FCNT_W'(BLINK_FRAMES - 1);

   logic [PCNT_W-1:0]   r_pcnt;
   logic [IDX_W-1:0]    r_idx;
   logic [FCNT_W-1:0]   r_fcnt;
   logic                r_phase;
   logic [4*DIGITS-1:0] r_disp;
   logic [4*DIGITS-1:0] r_pend;
   logic                r_ready;

   logic                w_pwrap;
   logic                w_boundary;
   logic [DIGITS-1:0]   w_any_hi;
   logic [DIGITS-1:0]   w_lz_blank;
   logic                v_acc;
   logic [3:0]          w_nib;
   logic [6:0]          w_glyph;
   logic                w_blink_blank;
   logic [6:0]          w_seg_nxt;
   logic                w_dp_nxt;
   logic [DIGITS-1:0]   w_sel;

   assign w_pwrap    = (r_pcnt == c_LAST_PCNT);
   assign w_boundary = w_pwrap && (r_idx == c_LAST_IDX);

   // Suffix-OR: w_any_hi[i] is set when any nibble i..DIGITS-1 is nonzero.
   // A digit above 0 is a leading zero exactly when its suffix is all zero.
   always_comb begin
      v_acc      = 1'b0;
      w_any_hi   = '0;
      w_lz_blank = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_acc       = v_acc | (|r_disp[4*i +: 4]);
         w_any_hi[i] = v_acc;
      end
      if (i_blank_lz) begin
         w_lz_blank = ~w_any_hi;
      end
      w_lz_blank[0] = 1'b0;
   end

   assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

   seg7_glyph_rom u_glyph (
      .i_nibble (w_nib),
      .o_seg    (w_glyph)
   );

   always_comb begin
      w_sel         = '0;
      w_sel[r_idx]  = 1'b1;
      w_blink_blank = r_phase & i_blink_en[r_idx];
      w_seg_nxt     = w_glyph;
      w_dp_nxt      = ~i_dp_in[r_idx];
      if (w_blink_blank || w_lz_blank[r_idx]) begin
         w_seg_nxt = SEG_BLANK;
      end
      if (w_blink_blank) begin
         w_dp_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt       <= '0;
         r_idx        <= '0;
         r_fcnt       <= '0;
         r_phase      <= 1'b0;
         r_disp       <= '0;
         r_pend       <= '0;
         r_ready      <= 1'b1;
         o_seg        <= SEG_BLANK;
         o_dp         <= 1'b1;
         o_an         <= '1;
         o_frame_tick <= 1'b0;
      end else begin
         // Scan timing
         if (w_pwrap) begin
            r_pcnt <= '0;
            r_idx  <= (r_idx == c_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
         end else begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
         end

         // Blink phase flips every BLINK_FRAMES completed frames
         if (w_boundary) begin
            if (r_fcnt == c_LAST_FCNT) begin
               r_fcnt  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_fcnt <= r_fcnt + FCNT_W'(1);
            end
         end

         // Handshake: capture when idle; commit only on a later boundary.
         // A capture on a boundary cycle clears r_ready on that edge, so the
         // commit waits for the following boundary.
         if (r_ready && i_load) begin
            r_pend  <= i_value;
            r_ready <= 1'b0;
         end else if (!r_ready && w_boundary) begin
            r_disp  <= r_pend;
            r_ready <= 1'b1;
         end

         // Registered outputs reflect the pre-edge scan state
         o_seg        <= w_seg_nxt;
         o_dp         <= w_dp_nxt;
         o_an         <= ~w_sel;
         o_frame_tick <= w_boundary;
      end
   end

   assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (DIGITS=4,
//                SCAN_DIV=4, BLINK_FRAMES=2). A reference model derives the
//                expected outputs from the count of edges since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME        = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_value;
   logic        i_load;
   logic        i_blank_lz;
   logic [3:0]  i_dp_in;
   logic [3:0]  i_blink_en;
   logic        o_ready;
   logic [6:0]  o_seg;
   logic        o_dp;
   logic [3:0]  o_an;
   logic        o_frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_cnt   = 0;
   logic [15:0] m_disp  = '0;
   logic [15:0] m_pend  = '0;
   logic        m_ready = 1'b1;

   logic [6:0] c_glyph [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_value      (i_value),
      .i_load       (i_load),
      .o_ready      (o_ready),
      .i_blank_lz   (i_blank_lz),
      .i_dp_in      (i_dp_in),
      .i_blink_en   (i_blink_en),
      .o_seg        (o_seg),
      .o_dp         (o_dp),
      .o_an         (o_an),
      .o_frame_tick (o_frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock edge: predict outputs from the model, advance the model,
   // then compare after the edge.
   task automatic cycle();
      int         idx, frame;
      bit         phase, blinkb, lz;
      logic [3:0] nib;
      logic [6:0] e_seg;
      logic       e_dp, e_ft;
      logic [3:0] e_an;
      if (rst) begin
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
         m_cnt = 0; m_disp = '0; m_ready = 1'b1;
      end else begin
         idx    = (m_cnt / SCAN_DIV) % DIGITS;
         frame  = m_cnt / FRAME;
         phase  = ((frame / BLINK_FRAMES) % 2) == 1;
         blinkb = phase && i_blink_en[idx];
         nib    = 4'((m_disp >> (4 * idx)) & 16'hF);
         lz     = i_blank_lz && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
         e_seg  = (blinkb || lz) ? 7'h7F : c_glyph[nib];
         e_dp   = blinkb ? 1'b1 : ~i_dp_in[idx];
         e_an   = ~(4'b0001 << idx);
         e_ft   = (m_cnt % FRAME) == FRAME - 1;
         if (m_ready && i_load) begin
            m_pend  = i_value;
            m_ready = 1'b0;
         end else if (!m_ready && e_ft) begin
            m_disp  = m_pend;
            m_ready = 1'b1;
         end
         m_cnt++;
      end
      @(posedge clk);
      #1;
      chk("seg",   32'(o_seg),        32'(e_seg));
      chk("dp",    32'(o_dp),         32'(e_dp));
      chk("an",    32'(o_an),         32'(e_an));
      chk("ftick", 32'(o_frame_tick), 32'(e_ft));
      chk("ready", 32'(o_ready),      32'(m_ready));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 4 * FRAME && !m_ready; k++) cycle();
      chk("wait_ready", 32'(m_ready), 32'd1);
   endtask

   task automatic do_load(input logic [15:0] v);
      wait_ready();
      i_value = v;
      i_load  = 1'b1;
      cycle();
      i_load  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_value = '0; i_load = 1'b0;
      i_blank_lz = 1'b0; i_dp_in = '0; i_blink_en = '0;
      #2;
      // Reset held three cycles, then release
      run(3);
      rst = 1'b0;
      cycle();
      chk("rel_an",  32'(o_an),  32'hE);
      chk("rel_seg", 32'(o_seg), 32'b0000001);

      // Plain load, then a full displayed frame
      do_load(16'h12A0);
      run(3 * FRAME);

      // Leading-zero blanking
      i_blank_lz = 1'b1;
      do_load(16'h0030);
      run(2 * FRAME + 2);
      do_load(16'h0000);
      run(2 * FRAME + 2);
      i_blank_lz = 1'b0;

      // Load while busy is ignored
      do_load(16'h1111);
      i_value = 16'h2222; i_load = 1'b1;
      cycle();
      i_load = 1'b0;
      run(2 * FRAME);

      // Load exactly on a boundary cycle
      wait_ready();
      for (int k = 0; k < FRAME && (m_cnt % FRAME) != FRAME - 1; k++) cycle();
      do_load(16'h5A5A);
      run(3 * FRAME);

      // Reset with an update pending
      do_load(16'hBEEF);
      run(3);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(FRAME);

      // Blink and decimal point on digit 0 across several frames
      rst = 1'b1; cycle(); rst = 1'b0;
      i_dp_in = 4'b0001; i_blink_en = 4'b0001;
      do_load(16'h4321);
      run(6 * FRAME);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         i_value    = 16'($urandom);
         i_load     = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) i_blank_lz = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 19) == 0) i_dp_in    = 4'($urandom);
         if ($urandom_range(0, 29) == 0) i_blink_en = 4'($urandom);
         rst        = ($urandom_range(0, 399) == 0);
         cycle();
      end
      rst = 1'b0; i_load = 1'b0;
      run(FRAME);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
